// File: rtl/axis_bram_master_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_bram_master_pkg : state encodings for the BRAM-to-AXIS streamer |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package axis_bram_master_pkg;

  localparam int STATE_W = 2;
  typedef logic [STATE_W-1:0] axis_m_state_t;

  localparam axis_m_state_t AXIS_M_IDLE  = 2'd0;
  localparam axis_m_state_t AXIS_M_READ  = 2'd1;
  localparam axis_m_state_t AXIS_M_DRAIN = 2'd2;

endpackage
`default_nettype wire

// File: rtl/axis_out_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_out_fifo : synchronous FIFO with a first-word-fall-through head |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module axis_out_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == c_last_ptr) ? '0 : p + PTR_W'(1);
  endfunction

  // Popping an empty FIFO is a no-op so the consumer can hold pop high.
  assign w_pop = pop && head_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push)
        r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)
        r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      r_mem[r_wr_ptr] <= push_data;
  end

  assign head_data  = r_mem[r_rd_ptr];
  assign head_valid = (r_count != '0);
  assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/axis_bram_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_bram_master : streams an FFT result frame from BRAM onto AXIS   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module axis_bram_master
  import axis_bram_master_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int FFT_SIZE   = 4096,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int ADDR_WIDTH = $clog2(FFT_SIZE),
  localparam int BYTE_COUNT = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  axis_bram_master_go,
  output logic                  axis_bram_master_busy,
  output logic                  axis_bram_master_done,
  output logic [ADDR_WIDTH-1:0] axis_mem2m_raddr,
  output logic                  axis_mem2m_re,
  input  logic [DATA_WIDTH-1:0] axis_mem2m_rdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [BYTE_COUNT-1:0] m_axis_tkeep
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  localparam logic [ADDR_WIDTH:0]   c_last_issue = (ADDR_WIDTH + 1)'(FFT_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] c_last_beat  = ADDR_WIDTH'(FFT_SIZE - 1);
  localparam logic [SUM_W-1:0]      c_depth      = SUM_W'(FIFO_DEPTH);

  axis_m_state_t         r_state;
  axis_m_state_t         w_next_state;
  logic [ADDR_WIDTH-1:0] r_rd_cnt;
  logic [ADDR_WIDTH:0]   r_issued;
  logic [ADDR_WIDTH-1:0] r_wr_cnt;
  logic [RD_LATENCY-1:0] r_pipe;
  logic                  r_done;

  logic [CNT_W-1:0]      w_inflight;
  logic [CNT_W-1:0]      w_fifo_count;
  logic                  w_credit_ok;
  logic                  w_push;
  logic                  w_last_flag;
  logic [DATA_WIDTH:0]   w_head;
  logic                  w_head_valid;
  logic                  w_last_hs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= AXIS_M_IDLE;
    else
      r_state <= w_next_state;
  end

  // Leaving READ is keyed to the issued count, so the address wrap after
  // the final read never matters.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      AXIS_M_IDLE:  if (axis_bram_master_go) w_next_state = AXIS_M_READ;
      AXIS_M_READ:  if (axis_mem2m_re && (r_issued == c_last_issue)) w_next_state = AXIS_M_DRAIN;
      AXIS_M_DRAIN: if (w_last_hs) w_next_state = AXIS_M_IDLE;
      default:      w_next_state = AXIS_M_IDLE;
    endcase
  end

  always_comb begin
    axis_mem2m_re         = (r_state == AXIS_M_READ) && w_credit_ok;
    axis_bram_master_busy = (r_state != AXIS_M_IDLE);
  end

  // Reads in flight plus words already queued may never exceed the FIFO.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      w_inflight = w_inflight + CNT_W'(r_pipe[i]);
  end

  assign w_credit_ok = (SUM_W'(w_fifo_count) + SUM_W'(w_inflight)) < c_depth;
  assign w_push      = r_pipe[RD_LATENCY-1];
  assign w_last_flag = (r_wr_cnt == c_last_beat);
  assign w_last_hs   = w_head_valid && m_axis_tready && w_head[DATA_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_cnt <= '0;
      r_issued <= '0;
      r_wr_cnt <= '0;
      r_pipe   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_pipe <= (r_pipe << 1) | RD_LATENCY'(axis_mem2m_re);
      r_done <= w_last_hs;
      if (r_state == AXIS_M_IDLE) begin
        r_rd_cnt <= '0;
        r_issued <= '0;
        r_wr_cnt <= '0;
      end else begin
        if (axis_mem2m_re) begin
          r_rd_cnt <= r_rd_cnt + ADDR_WIDTH'(1);
          r_issued <= r_issued + (ADDR_WIDTH + 1)'(1);
        end
        if (w_push)
          r_wr_cnt <= r_wr_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  axis_out_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (w_push),
    .push_data  ({w_last_flag, axis_mem2m_rdata}),
    .pop        (m_axis_tready),
    .head_data  (w_head),
    .head_valid (w_head_valid),
    .count      (w_fifo_count)
  );

  assign axis_mem2m_raddr      = r_rd_cnt;
  assign axis_bram_master_done = r_done;
  assign m_axis_tvalid         = w_head_valid;
  assign m_axis_tlast          = w_head_valid && w_head[DATA_WIDTH];
  assign m_axis_tdata          = w_head[DATA_WIDTH-1:0];
  assign m_axis_tkeep          = '1;

endmodule
`default_nettype wire
